// File: rtl/rv32_pkg.sv
//------------------------------------------------------------------------------
// Module      : rv32_pkg
// Description : Shared RV32IM pipeline constants, fetch FSM states, opcodes.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package rv32_pkg;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0013;
    localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_DRAIN = 2'd3
    } fetch_state_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

endpackage

`default_nettype wire

// File: rtl/instruction_fetch_stage_if_id_register.sv
//------------------------------------------------------------------------------
// Module      : if_id_register
// Description : IF/ID pipeline register with load / hold / flush-to-bubble.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module if_id_register
    import rv32_pkg::*;
#(
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        i_load,
    input  logic        i_flush,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pc_plus4,
    output logic [31:0] o_instr,
    output logic        o_valid
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4_q, pc_plus4_d;
    logic [31:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    // Flush wins over load; a bubble keeps the PC fields of the last entry.
    always_comb begin
        pc_d       = pc_q;
        pc_plus4_d = pc_plus4_q;
        instr_d    = instr_q;
        valid_d    = valid_q;
        if (i_flush) begin
            instr_d = BUBBLE_INSTR;
            valid_d = 1'b0;
        end else if (i_load) begin
            pc_d       = i_pc;
            pc_plus4_d = i_pc + 32'd4;
            instr_d    = i_instr;
            valid_d    = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            pc_q       <= '0;
            pc_plus4_q <= '0;
            instr_q    <= BUBBLE_INSTR;
            valid_q    <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            pc_plus4_q <= pc_plus4_d;
            instr_q    <= instr_d;
            valid_q    <= valid_d;
        end
    end

    assign o_pc       = pc_q;
    assign o_pc_plus4 = pc_plus4_q;
    assign o_instr    = instr_q;
    assign o_valid    = valid_q;

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : instruction_fetch_stage
// Description : RV32IM IF stage: PC, imem handshake FSM, skid buffer, IF/ID.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module instruction_fetch_stage
    import rv32_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
    parameter logic [31:0] NOP_INSTR    = rv32_pkg::NOP_INSTR
) (
    input  logic        CLK,
    input  logic        RESET_N,
    input  logic        STALL,
    input  logic        BRANCH_TAKEN,
    input  logic [31:0] BRANCH_TARGET,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_RDATA,
    output logic        IMEM_READ,
    output logic [31:0] IMEM_ADDR,
    output logic [31:0] PC_ID,
    output logic [31:0] PC_PLUS4_ID,
    output logic [31:0] INSTRUCTION_ID,
    output logic        VALID_ID
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  skid_q, skid_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         w_ifid_load;
    logic         w_ifid_flush;
    logic [31:0]  w_ifid_instr;

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        skid_d       = skid_q;
        drain_addr_d = drain_addr_q;
        w_ifid_load  = 1'b0;
        w_ifid_flush = 1'b0;
        w_ifid_instr = skid_q;
        if (BRANCH_TAKEN) begin
            pc_d         = BRANCH_TARGET & ~32'h3;
            skid_d       = '0;
            w_ifid_flush = 1'b1;
            // An unanswered request must be drained at its original address.
            if (state_q == ST_FETCH && !IMEM_READY) begin
                state_d      = ST_DRAIN;
                drain_addr_d = pc_q;
            end else if (state_q == ST_DRAIN && !IMEM_READY) begin
                state_d = ST_DRAIN;
            end else begin
                state_d = ST_FETCH;
            end
        end else begin
            case (state_q)
                ST_IDLE: state_d = ST_FETCH;
                ST_FETCH: begin
                    if (IMEM_READY) begin
                        if (STALL) begin
                            skid_d  = IMEM_RDATA;
                            state_d = ST_HOLD;
                        end else begin
                            w_ifid_load  = 1'b1;
                            w_ifid_instr = IMEM_RDATA;
                            pc_d         = pc_q + 32'd4;
                        end
                    end else if (!STALL) begin
                        w_ifid_flush = 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (!STALL) begin
                        w_ifid_load = 1'b1;
                        pc_d        = pc_q + 32'd4;
                        state_d     = ST_FETCH;
                    end
                end
                ST_DRAIN: begin
                    w_ifid_flush = 1'b1;
                    if (IMEM_READY) begin
                        state_d = ST_FETCH;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q      <= ST_IDLE;
            pc_q         <= RESET_VECTOR;
            skid_q       <= '0;
            drain_addr_q <= '0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            skid_q       <= skid_d;
            drain_addr_q <= drain_addr_d;
        end
    end

    assign IMEM_READ = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
    assign IMEM_ADDR = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

    if_id_register #(
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .i_load     (w_ifid_load),
        .i_flush    (w_ifid_flush),
        .i_pc       (pc_q),
        .i_instr    (w_ifid_instr),
        .o_pc       (PC_ID),
        .o_pc_plus4 (PC_PLUS4_ID),
        .o_instr    (INSTRUCTION_ID),
        .o_valid    (VALID_ID)
    );

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_stage.sv
//------------------------------------------------------------------------------
// Module      : tb_instruction_fetch_stage
// Description : Directed self-checking bench for instruction_fetch_stage.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_instruction_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET_N;
    logic        STALL;
    logic        BRANCH_TAKEN;
    logic [31:0] BRANCH_TARGET;
    logic        IMEM_READY;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] PC_ID;
    logic [31:0] PC_PLUS4_ID;
    logic [31:0] INSTRUCTION_ID;
    logic        VALID_ID;

    int checks = 0;
    int errors = 0;

    always #5 CLK = ~CLK;

    // Memory image: every word is its address tagged with bit 28.
    assign IMEM_RDATA = IMEM_ADDR | 32'h1000_0000;

    instruction_fetch_stage dut (
        .CLK            (CLK),
        .RESET_N        (RESET_N),
        .STALL          (STALL),
        .BRANCH_TAKEN   (BRANCH_TAKEN),
        .BRANCH_TARGET  (BRANCH_TARGET),
        .IMEM_READY     (IMEM_READY),
        .IMEM_RDATA     (IMEM_RDATA),
        .IMEM_READ      (IMEM_READ),
        .IMEM_ADDR      (IMEM_ADDR),
        .PC_ID          (PC_ID),
        .PC_PLUS4_ID    (PC_PLUS4_ID),
        .INSTRUCTION_ID (INSTRUCTION_ID),
        .VALID_ID       (VALID_ID)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic check_ifid(input string tag, input logic [31:0] instr,
                              input logic valid, input logic [31:0] pc);
        check({tag, "_instr"}, INSTRUCTION_ID, instr);
        check({tag, "_valid"}, {31'd0, VALID_ID}, {31'd0, valid});
        check({tag, "_pc"}, PC_ID, pc);
    endtask

    task automatic check_mem(input string tag, input logic rd, input logic [31:0] addr);
        check({tag, "_read"}, {31'd0, IMEM_READ}, {31'd0, rd});
        check({tag, "_addr"}, IMEM_ADDR, addr);
    endtask

    initial begin
        RESET_N       = 1'b0;
        STALL         = 1'b0;
        BRANCH_TAKEN  = 1'b0;
        BRANCH_TARGET = '0;
        IMEM_READY    = 1'b1;
        repeat (2) step();
        check_ifid("rst", 32'h0000_0013, 1'b0, 32'h0);
        check("rst_pc4", PC_PLUS4_ID, 32'h0);
        check_mem("rst", 1'b0, 32'h0);

        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        check_mem("idle2fetch", 1'b1, 32'h0);
        check("idle2fetch_valid", {31'd0, VALID_ID}, 32'd0);
        step();
        check_ifid("first", 32'h1000_0000, 1'b1, 32'h0);
        check("first_pc4", PC_PLUS4_ID, 32'h4);
        check_mem("first", 1'b1, 32'h4);

        // Wait states at 0x4
        IMEM_READY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_ifid("wait", 32'h0000_0013, 1'b0, 32'h0);
            check_mem("wait", 1'b1, 32'h4);
        end
        IMEM_READY = 1'b1;
        step();
        check_ifid("after_wait", 32'h1000_0004, 1'b1, 32'h4);
        check("after_wait_pc4", PC_PLUS4_ID, 32'h8);
        check_mem("after_wait", 1'b1, 32'h8);

        // Stall while data returns at 0x8: goes through skid buffer
        STALL = 1'b1;
        step();
        check_ifid("hold1", 32'h1000_0004, 1'b1, 32'h4);
        check_mem("hold1", 1'b0, 32'h8);
        step();
        check_ifid("hold2", 32'h1000_0004, 1'b1, 32'h4);
        check_mem("hold2", 1'b0, 32'h8);
        STALL = 1'b0;
        step();
        check_ifid("unhold", 32'h1000_0008, 1'b1, 32'h8);
        check_mem("unhold", 1'b1, 32'hC);

        // Branch while 0xC outstanding
        IMEM_READY = 1'b0;
        step();
        check_ifid("pre_br", 32'h0000_0013, 1'b0, 32'h8);
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'h100;
        step();
        BRANCH_TAKEN = 1'b0;
        check_ifid("br_flush", 32'h0000_0013, 1'b0, 32'h8);
        check_mem("drain1", 1'b1, 32'hC);
        step();
        check_mem("drain2", 1'b1, 32'hC);
        check("drain2_valid", {31'd0, VALID_ID}, 32'd0);
        IMEM_READY = 1'b1;
        step();
        check_ifid("drain_done", 32'h0000_0013, 1'b0, 32'h8);
        check_mem("drain_done", 1'b1, 32'h100);
        step();
        check_ifid("tgt", 32'h1000_0100, 1'b1, 32'h100);
        check_mem("tgt", 1'b1, 32'h104);

        // Branch beats stall; misaligned target is truncated
        BRANCH_TAKEN  = 1'b1;
        STALL         = 1'b1;
        BRANCH_TARGET = 32'h203;
        step();
        BRANCH_TAKEN = 1'b0;
        STALL        = 1'b0;
        check_ifid("br_stall", 32'h0000_0013, 1'b0, 32'h100);
        check_mem("br_stall", 1'b1, 32'h200);
        step();
        check_ifid("tgt2", 32'h1000_0200, 1'b1, 32'h200);
        check_mem("tgt2", 1'b1, 32'h204);

        // PC wraps modulo 2^32
        BRANCH_TAKEN  = 1'b1;
        BRANCH_TARGET = 32'hFFFF_FFFC;
        step();
        BRANCH_TAKEN = 1'b0;
        check_mem("wrap_pre", 1'b1, 32'hFFFF_FFFC);
        step();
        check_ifid("wrap", 32'hFFFF_FFFC, 1'b1, 32'hFFFF_FFFC);
        check("wrap_pc4", PC_PLUS4_ID, 32'h0);
        check_mem("wrap", 1'b1, 32'h0);

        // Asynchronous reset between edges
        step();
        #2;
        RESET_N = 1'b0;
        #1;
        check_ifid("async_rst", 32'h0000_0013, 1'b0, 32'h0);
        check_mem("async_rst", 1'b0, 32'h0);
        @(negedge CLK);
        RESET_N = 1'b1;
        step();
        check_mem("refetch", 1'b1, 32'h0);
        step();
        check_ifid("refetch", 32'h1000_0000, 1'b1, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
